// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM datapath: duty code type and counter widths.
package pwm_pkg;

  localparam int unsigned DUTY_W    = 4;
  localparam int unsigned PWM_CBITS = 13;

  typedef logic [DUTY_W-1:0] duty_t;

  // One code toward tgt; callers guarantee cur != tgt, so no wrap is possible.
  function automatic duty_t step_toward(duty_t cur, duty_t tgt);
    return (tgt > cur) ? duty_t'(cur + 1'b1) : duty_t'(cur - 1'b1);
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus whole-vector debouncer for the raw duty switches.
module sw_debounce #(
  parameter int unsigned W         = 4,
  parameter int unsigned DBNC_BITS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] sw_raw_i,
  output logic [W-1:0] target_o,
  output logic [W-1:0] target_nxt_c,
  output logic         stable_o
);

  logic [W-1:0]         sync1_q, sync1_d;
  logic [W-1:0]         sync2_q, sync2_d;
  logic [W-1:0]         cand_q, cand_d;
  logic [DBNC_BITS-1:0] dcnt_q, dcnt_d;
  logic [W-1:0]         target_q, target_d;
  logic                 stable_q, stable_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      dcnt_q   <= '0;
      target_q <= '0;
      stable_q <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cand_q   <= cand_d;
      dcnt_q   <= dcnt_d;
      target_q <= target_d;
      stable_q <= stable_d;
    end
  end

  // Any bit change restarts the count for the whole vector.
  always_comb begin
    sync1_d  = sw_raw_i;
    sync2_d  = sync1_q;
    cand_d   = cand_q;
    dcnt_d   = dcnt_q;
    target_d = target_q;
    stable_d = 1'b0;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      dcnt_d = '0;
    end else if (dcnt_q != '1) begin
      dcnt_d = DBNC_BITS'(dcnt_q + 1'b1);
    end else begin
      target_d = cand_q;
      stable_d = 1'b1;
    end
  end

  assign target_o     = target_q;
  assign target_nxt_c = target_d;
  assign stable_o     = stable_q;

endmodule

// File: rtl/pwm_duty_ramp.sv
// Debounces the duty switches and slews the PWM duty code one step per ramp period.
module pwm_duty_ramp
  import pwm_pkg::*;
#(
  parameter int unsigned DBNC_BITS = 4,
  parameter int unsigned RAMP_BITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DUTY_W-1:0] sw_raw,
  output logic [DUTY_W-1:0] duty,
  output logic              busy,
  output logic              step
);

  duty_t                target;
  duty_t                target_nxt;
  logic                 stable;

  duty_t                duty_q, duty_d;
  logic [RAMP_BITS-1:0] rcnt_q, rcnt_d;
  logic                 busy_q, busy_d;
  logic                 step_q, step_d;

  sw_debounce #(
    .W         (DUTY_W),
    .DBNC_BITS (DBNC_BITS)
  ) u_dbnc (
    .clk          (clk),
    .rst          (rst),
    .sw_raw_i     (sw_raw),
    .target_o     (target),
    .target_nxt_c (target_nxt),
    .stable_o     (stable)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q <= '0;
      rcnt_q <= '0;
      busy_q <= 1'b0;
      step_q <= 1'b0;
    end else begin
      duty_q <= duty_d;
      rcnt_q <= rcnt_d;
      busy_q <= busy_d;
      step_q <= step_d;
    end
  end

  // The prescaler keeps its phase across retargets; it only clears once duty has arrived.
  always_comb begin
    duty_d = duty_q;
    rcnt_d = rcnt_q;
    if (duty_q == target) begin
      rcnt_d = '0;
    end else begin
      rcnt_d = RAMP_BITS'(rcnt_q + 1'b1);
      if (rcnt_q == '1) begin
        duty_d = step_toward(duty_q, target);
      end
    end
    busy_d = (duty_d != target_nxt);
    step_d = (duty_d != duty_q);
  end

  assign duty = duty_q;
  assign busy = busy_q;
  assign step = step_q;

  a_duty_needs_step : assert property (@(posedge clk) disable iff (rst)
    (!$past(rst) && (duty != $past(duty))) |-> step)
    else $error("duty changed without step");

  a_duty_slew : assert property (@(posedge clk) disable iff (rst)
    !$past(rst) |-> (DUTY_W'(duty - $past(duty)) inside {4'd0, 4'd1, 4'd15}))
    else $error("duty moved by more than one code");

  a_busy_match : assert property (@(posedge clk) disable iff (rst)
    busy == (duty != target))
    else $error("busy inconsistent with duty/target");

  a_target_when_stable : assert property (@(posedge clk) disable iff (rst)
    (!$past(rst) && (target != $past(target))) |-> stable)
    else $error("target changed without stable input");

endmodule
